// File: rtl/dpram_be_init.sv
// True dual-port byte-enable RAM with post-reset clear sweep and optional output register.
// Define DPRAM_COLL_DET_EN to add the registered same-address collision flag coll_err.
module dpram_be_init #(
    parameter int                 DEPTH    = 1024,
    parameter int                 D_WIDTH  = 32,
    parameter int                 BE_WIDTH = D_WIDTH / 8,
    parameter int                 RD_MODE  = 0,
    parameter int                 OUT_REG  = 0,
    parameter logic [D_WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_busy,
`ifdef DPRAM_COLL_DET_EN
    output logic                     coll_err,
`endif
    input  logic                     en_a,
    input  logic [BE_WIDTH-1:0]      we_a,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [D_WIDTH-1:0]       d_in_a,
    output logic [D_WIDTH-1:0]       d_out_a,
    output logic                     rvalid_a,
    input  logic                     en_b,
    input  logic [BE_WIDTH-1:0]      we_b,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    input  logic [D_WIDTH-1:0]       d_in_b,
    output logic [D_WIDTH-1:0]       d_out_b,
    output logic                     rvalid_b
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic clr_we;
    logic ready;

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [D_WIDTH-1:0] q_a, q_b;
    logic v_a, v_b;

    function automatic logic [D_WIDTH-1:0] merge(
        input logic [D_WIDTH-1:0]  old,
        input logic [D_WIDTH-1:0]  din,
        input logic [BE_WIDTH-1:0] be
    );
        logic [D_WIDTH-1:0] r;
        r = old;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        unique case (state)
            CLEAR: begin
                clr_we  = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) state_nxt = READY;
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign init_busy = (state == CLEAR);
    assign ready     = (state == READY);

    // A is written last so its enabled bytes win on a shared address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[cnt] <= INIT_VAL;
            end else if (ready) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (en_b && we_b[i]) mem[addr_b][8*i +: 8] <= d_in_b[8*i +: 8];
                    if (en_a && we_a[i]) mem[addr_a][8*i +: 8] <= d_in_a[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_a <= '0;
            v_a <= 1'b0;
        end else begin
            v_a <= 1'b0;
            if (ready && en_a) begin
                if (we_a == '0 || RD_MODE == 1) begin
                    q_a <= mem[addr_a];
                    v_a <= 1'b1;
                end else if (RD_MODE == 0) begin
                    q_a <= merge(mem[addr_a], d_in_a, we_a);
                    v_a <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_b <= '0;
            v_b <= 1'b0;
        end else begin
            v_b <= 1'b0;
            if (ready && en_b) begin
                if (we_b == '0 || RD_MODE == 1) begin
                    q_b <= mem[addr_b];
                    v_b <= 1'b1;
                end else if (RD_MODE == 0) begin
                    q_b <= merge(mem[addr_b], d_in_b, we_b);
                    v_b <= 1'b1;
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk) begin
                if (rst) begin
                    d_out_a  <= '0;
                    rvalid_a <= 1'b0;
                    d_out_b  <= '0;
                    rvalid_b <= 1'b0;
                end else begin
                    d_out_a  <= q_a;
                    rvalid_a <= v_a;
                    d_out_b  <= q_b;
                    rvalid_b <= v_b;
                end
            end
        end else begin : g_direct
            assign d_out_a  = q_a;
            assign rvalid_a = v_a;
            assign d_out_b  = q_b;
            assign rvalid_b = v_b;
        end
    endgenerate

`ifdef DPRAM_COLL_DET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_err <= 1'b0;
        end else begin
            coll_err <= ready && en_a && en_b && (addr_a == addr_b)
                        && ((we_a | we_b) != '0);
        end
    end
`endif

endmodule

// File: tb/tb_dpram_be_init.sv
// Bench for dpram_be_init: four instances (write-first, read-first, no-change, registered)
// share one stimulus stream and are compared against a word-level memory model.
module tb_dpram_be_init;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [3:0]  we_a = '0, we_b = '0;
    logic [3:0]  addr_a = '0, addr_b = '0;
    logic [31:0] d_in_a = '0, d_in_b = '0;

    logic        busy [4];
    logic [31:0] dq_a [4];
    logic [31:0] dq_b [4];
    logic        rv_a [4];
    logic        rv_b [4];
`ifdef DPRAM_COLL_DET_EN
    logic        coll [4];
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        dpram_be_init #(
            .DEPTH(16),
            .D_WIDTH(32),
            .RD_MODE((k == 3) ? 0 : k),
            .OUT_REG((k == 3) ? 1 : 0),
            .INIT_VAL(IV)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .init_busy(busy[k]),
`ifdef DPRAM_COLL_DET_EN
            .coll_err(coll[k]),
`endif
            .en_a(en_a),
            .we_a(we_a),
            .addr_a(addr_a),
            .d_in_a(d_in_a),
            .d_out_a(dq_a[k]),
            .rvalid_a(rv_a[k]),
            .en_b(en_b),
            .we_b(we_b),
            .addr_b(addr_b),
            .d_in_b(d_in_b),
            .d_out_b(dq_b[k]),
            .rvalid_b(rv_b[k])
        );
    end

    // Reference: memory contents plus the expected output of each instance.
    int          mode_m [4] = '{0, 1, 2, 0};
    bit          oreg_m [4] = '{0, 0, 0, 1};
    logic [31:0] mem_m [16];
    bit          busy_m = 1'b1;
    int          clr = 0;
    bit          coll_m = 1'b0;
    logic [31:0] s1q [4][2];
    bit          s1v [4][2];
    logic [31:0] oq [4][2];
    bit          ov [4][2];

    function automatic logic [31:0] bmerge(logic [31:0] old, logic [31:0] din, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        en_p [2];
        logic [3:0]  we_p [2];
        logic [3:0]  ad_p [2];
        logic [31:0] di_p [2];
        logic [31:0] old_p [2];
        en_p = '{en_a, en_b};
        we_p = '{we_a, we_b};
        ad_p = '{addr_a, addr_b};
        di_p = '{d_in_a, d_in_b};
        if (rst) begin
            busy_m = 1'b1;
            clr    = 0;
            coll_m = 1'b0;
            for (int k = 0; k < 4; k++)
                for (int p = 0; p < 2; p++) begin
                    s1q[k][p] = '0; s1v[k][p] = 1'b0;
                    oq[k][p]  = '0; ov[k][p]  = 1'b0;
                end
        end else begin
            coll_m = 1'b0;
            for (int k = 0; k < 4; k++)
                for (int p = 0; p < 2; p++)
                    if (oreg_m[k]) begin oq[k][p] = s1q[k][p]; ov[k][p] = s1v[k][p]; end
            if (busy_m) begin
                mem_m[clr] = IV;
                clr++;
                if (clr == 16) busy_m = 1'b0;
                for (int k = 0; k < 4; k++)
                    for (int p = 0; p < 2; p++) s1v[k][p] = 1'b0;
            end else begin
                for (int p = 0; p < 2; p++) old_p[p] = mem_m[ad_p[p]];
                for (int k = 0; k < 4; k++)
                    for (int p = 0; p < 2; p++) begin
                        s1v[k][p] = 1'b0;
                        if (en_p[p]) begin
                            if (we_p[p] == 4'b0 || mode_m[k] == 1) begin
                                s1q[k][p] = old_p[p]; s1v[k][p] = 1'b1;
                            end else if (mode_m[k] == 0) begin
                                s1q[k][p] = bmerge(old_p[p], di_p[p], we_p[p]);
                                s1v[k][p] = 1'b1;
                            end
                        end
                    end
                for (int p = 1; p >= 0; p--)
                    if (en_p[p] && we_p[p] != 4'b0)
                        mem_m[ad_p[p]] = bmerge(mem_m[ad_p[p]], di_p[p], we_p[p]);
                coll_m = en_a && en_b && (addr_a == addr_b) && ((we_a | we_b) != 4'b0);
            end
            for (int k = 0; k < 4; k++)
                for (int p = 0; p < 2; p++)
                    if (!oreg_m[k]) begin oq[k][p] = s1q[k][p]; ov[k][p] = s1v[k][p]; end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("busy%0d", k), {31'b0, busy[k]}, {31'b0, busy_m});
            chk($sformatf("dout_a%0d", k), dq_a[k], oq[k][0]);
            chk($sformatf("dout_b%0d", k), dq_b[k], oq[k][1]);
            chk($sformatf("rv_a%0d", k), {31'b0, rv_a[k]}, {31'b0, ov[k][0]});
            chk($sformatf("rv_b%0d", k), {31'b0, rv_b[k]}, {31'b0, ov[k][1]});
`ifdef DPRAM_COLL_DET_EN
            chk($sformatf("coll%0d", k), {31'b0, coll[k]}, {31'b0, coll_m});
`endif
        end
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = '0;
        en_b = 1'b0; we_b = '0;
    endtask

    task automatic drv_a(logic e, logic [3:0] w, logic [3:0] ad, logic [31:0] d);
        en_a = e; we_a = w; addr_a = ad; d_in_a = d;
    endtask

    task automatic drv_b(logic e, logic [3:0] w, logic [3:0] ad, logic [31:0] d);
        en_b = e; we_b = w; addr_b = ad; d_in_b = d;
    endtask

    initial begin
        int n;
        // reset and sweep length
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (busy[0] && n < 40) begin
            n++;
            step();
        end
        chk("busy_len", n, 16);

        // every word cleared on both ports
        for (int i = 0; i < 16; i++) begin
            drv_a(1'b1, 4'b0, 4'(i), '0);
            drv_b(1'b1, 4'b0, 4'(15 - i), '0);
            step();
            chk("clr_a", dq_a[0], IV);
            chk("clr_b", dq_b[0], IV);
        end
        idle();

        // partial byte write
        drv_a(1'b1, 4'b1111, 4'd3, 32'h11223344);
        step();
        drv_a(1'b1, 4'b0101, 4'd3, 32'hFFFFFFFF);
        step();
        drv_a(1'b1, 4'b0000, 4'd3, 32'h0);
        step();
        chk("be_merge", dq_a[0], 32'h11FF33FF);
        idle();

        // dual write to the same word
        drv_a(1'b1, 4'b0011, 4'd5, 32'h000000AA);
        drv_b(1'b1, 4'b1110, 4'd5, 32'hBBBBBB00);
        step();
`ifdef DPRAM_COLL_DET_EN
        chk("coll_ww", {31'b0, coll[0]}, 32'd1);
`endif
        idle();
        drv_b(1'b1, 4'b0000, 4'd5, 32'h0);
        step();
        chk("dual_wr", dq_b[0], 32'hBBBB00AA);
        idle();

        // write on A while B reads the same word
        drv_a(1'b1, 4'b1111, 4'd7, 32'hDEADBEEF);
        drv_b(1'b1, 4'b0000, 4'd7, 32'h0);
        step();
        chk("rw_b_old", dq_b[0], IV);
        chk("rw_wf", dq_a[0], 32'hDEADBEEF);
        chk("rw_rf", dq_a[1], IV);
        chk("rw_nc_rv", {31'b0, rv_a[2]}, 32'd0);
        idle();

        // registered output latency and back-to-back reads
        step();
        drv_a(1'b1, 4'b0, 4'd0, '0);
        step();
        chk("oreg_lat1", {31'b0, rv_a[3]}, 32'd0);
        drv_a(1'b1, 4'b0, 4'd1, '0);
        step();
        chk("oreg_lat2", {31'b0, rv_a[3]}, 32'd1);
        drv_a(1'b1, 4'b0, 4'd2, '0);
        step();
        chk("oreg_b2b", dq_a[3], IV);
        idle();
        step();
        chk("oreg_b2b2", {31'b0, rv_a[3]}, 32'd1);
        step();
        chk("oreg_end", {31'b0, rv_a[3]}, 32'd0);

        // reset mid-sweep restarts the clear
        drv_a(1'b1, 4'b1111, 4'd15, 32'h1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("swp_rv", {31'b0, rv_a[0]}, 32'd0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (busy[0] && n < 40) begin
            n++;
            step();
        end
        chk("busy_len2", n, 16);
        drv_a(1'b1, 4'b0, 4'd15, '0);
        step();
        chk("swp_a15", dq_a[0], IV);
        idle();

        // random traffic with frequent address overlap
        for (int i = 0; i < 400; i++) begin
            drv_a($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom),
                  4'($urandom_range(0, 15)), $urandom);
            drv_b($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom),
                  ($urandom_range(0, 1) == 0) ? addr_a : 4'($urandom_range(0, 15)),
                  $urandom);
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
